retire_trace_buffer: RTL and testbench

Synthesizable commit-trace capture block that sits directly downstream of the pipeline's write-back stage. Every retiring instruction is captured into a cycle-stamped record in a FIFO. Records drain to a trace consumer (bench checker, debug port) over a valid/ready handshake. On HLT it stops capturing, drains the remaining records, then asserts `done`.

---
 rtl/retire_trace_buffer.sv | 164 ++++++++++++++++
 tb/tb_retire_trace_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_buffer.sv
// Commit-trace capture FIFO: stamps every retiring instruction with the run
// cycle count, queues it, and drains it over a valid/ready port. After HLT the
// block stops capturing, drains what is queued, then raises done.
module retire_trace_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CYC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  logic [15:0]      wb_pc,
  input  logic [15:0]      wb_instr,
  input  logic             wb_rf_we,
  input  logic [3:0]       wb_rd,
  input  logic [15:0]      wb_rf_wdata,
  input  logic             wb_hlt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CYC_W-1:0] out_cycle,
  output logic [15:0]      out_pc,
  output logic [15:0]      out_instr,
  output logic             out_rf_we,
  output logic [3:0]       out_rd,
  output logic [15:0]      out_wdata,
  output logic             out_hlt,
  output logic [CYC_W-1:0] cycle_cnt,
  output logic [CYC_W-1:0] retired_cnt,
  output logic [15:0]      dropped_cnt,
  output logic             overflow,
  output logic             done
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam int unsigned REC_W = CYC_W + 16 + 16 + 1 + 4 + 16 + 1;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [REC_W-1:0] mem_q [DEPTH];

  logic [1:0]       state_q,    state_d;
  logic [AW-1:0]    wptr_q,     wptr_d;
  logic [AW-1:0]    rptr_q,     rptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [CYC_W-1:0] cycle_q,    cycle_d;
  logic [CYC_W-1:0] retired_q,  retired_d;
  logic [15:0]      dropped_q,  dropped_d;
  logic             overflow_q, overflow_d;

  logic             pop;
  logic             push;
  logic             push_req;
  logic             full;
  logic [REC_W-1:0] head;
  logic [REC_W-1:0] wr_rec;

  // Handshake qualification; a full FIFO still accepts a push when it pops.
  always_comb begin
    out_valid = (count_q != '0);
    full      = (count_q == CNT_W'(DEPTH));
    pop       = out_valid && out_ready;
    push_req  = wb_valid && (state_q == ST_RUN);
    push      = push_req && (!full || pop);
    head      = mem_q[rptr_q];
    wr_rec    = {cycle_q, wb_pc, wb_instr, wb_rf_we, wb_rd, wb_rf_wdata, wb_hlt};
  end

  // Next-state: pointers, occupancy, counters and the RUN/DRAIN/DONE sequence.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    cycle_d    = cycle_q;
    retired_d  = retired_q;
    dropped_d  = dropped_q;
    overflow_d = overflow_q;

    if (push) begin
      wptr_d    = wptr_q + AW'(1);
      retired_d = retired_q + CYC_W'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    if (push_req && !push) begin
      overflow_d = 1'b1;
      if (dropped_q != 16'hFFFF) begin
        dropped_d = dropped_q + 16'(1);
      end
    end

    case (state_q)
      ST_RUN: begin
        cycle_d = cycle_q + CYC_W'(1);
        if (push_req && wb_hlt) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (count_d == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Control and counter registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      cycle_q    <= '0;
      retired_q  <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      cycle_q    <= cycle_d;
      retired_q  <= retired_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
    end
  end

  // Record storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wptr_q] <= wr_rec;
    end
  end

  // Head record presented combinationally, zeroed while nothing is queued.
  always_comb begin
    {out_cycle, out_pc, out_instr, out_rf_we, out_rd, out_wdata, out_hlt} =
      out_valid ? head : '0;
  end

  assign cycle_cnt   = cycle_q;
  assign retired_cnt = retired_q;
  assign dropped_cnt = dropped_q;
  assign overflow    = overflow_q;
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer: stimulus queues expected records,
// a negedge monitor pops and compares every handshake and checks gating.
module tb_retire_trace_buffer;

  typedef logic [85:0] rec_t;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [15:0] wb_pc;
  logic [15:0] wb_instr;
  logic        wb_rf_we;
  logic [3:0]  wb_rd;
  logic [15:0] wb_rf_wdata;
  logic        wb_hlt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_cycle;
  logic [15:0] out_pc;
  logic [15:0] out_instr;
  logic        out_rf_we;
  logic [3:0]  out_rd;
  logic [15:0] out_wdata;
  logic        out_hlt;
  logic [31:0] cycle_cnt;
  logic [31:0] retired_cnt;
  logic [15:0] dropped_cnt;
  logic        overflow;
  logic        done;

  int   vectors = 0;
  int   fails   = 0;
  rec_t sb[$];
  int   tb_cyc  = 0;
  bit   tb_run  = 1'b1;

  retire_trace_buffer #(.DEPTH(16), .CYC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
    .wb_rf_we(wb_rf_we), .wb_rd(wb_rd), .wb_rf_wdata(wb_rf_wdata),
    .wb_hlt(wb_hlt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cycle(out_cycle), .out_pc(out_pc), .out_instr(out_instr),
    .out_rf_we(out_rf_we), .out_rd(out_rd), .out_wdata(out_wdata),
    .out_hlt(out_hlt),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt),
    .dropped_cnt(dropped_cnt), .overflow(overflow), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare each accepted head record, and zero payload when idle.
  always @(negedge clk) begin
    rec_t got;
    rec_t exp;
    got = {out_cycle, out_pc, out_instr, out_rf_we, out_rd, out_wdata, out_hlt};
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (out_ready === 1'b1) begin
          vectors++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pop: got record %h, expected no record", got);
          end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
              fails++;
              $display("FAIL record: got %h expected %h", got, exp);
            end
          end
        end
      end else begin
        vectors++;
        if (got !== '0) begin
          fails++;
          $display("FAIL payload_gating: got %h expected 0", got);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    if (tb_run) tb_cyc++;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    wb_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    sb.delete();
    tb_cyc = 0;
    tb_run = 1'b1;
  endtask

  task automatic retire(input logic [15:0] pc, input logic [15:0] instr,
                        input logic we, input logic [3:0] rd,
                        input logic [15:0] wd, input logic hlt, input bit accept);
    wb_valid    = 1'b1;
    wb_pc       = pc;
    wb_instr    = instr;
    wb_rf_we    = we;
    wb_rd       = rd;
    wb_rf_wdata = wd;
    wb_hlt      = hlt;
    if (accept) sb.push_back({32'(tb_cyc), pc, instr, we, rd, wd, hlt});
    step();
    wb_valid = 1'b0;
    wb_hlt   = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int k;
    k = 0;
    while (sb.size() != 0 && k < max_cyc) begin
      step();
      k++;
    end
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d records left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"},    32'(out_valid), 32'd0);
    chk({name, "_payload"},  32'(|{out_cycle, out_pc, out_instr, out_rf_we,
                                   out_rd, out_wdata, out_hlt}), 32'd0);
    chk({name, "_cycle"},    cycle_cnt, 32'd0);
    chk({name, "_retired"},  retired_cnt, 32'd0);
    chk({name, "_dropped"},  32'(dropped_cnt), 32'd0);
    chk({name, "_overflow"}, 32'(overflow), 32'd0);
    chk({name, "_done"},     32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; wb_pc = '0; wb_instr = '0; wb_rf_we = 1'b0;
    wb_rd = '0; wb_rf_wdata = '0; wb_hlt = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #2;
    do_reset();
    chk_all_zero("reset");

    // Single retire at cycle 3
    out_ready = 1'b1;
    step(); step(); step();
    retire(16'h0004, 16'hA123, 1'b1, 4'd3, 16'h00FF, 1'b0, 1'b1);
    chk("single_valid_hi", 32'(out_valid), 32'd1);
    chk("single_stamp", out_cycle, 32'd3);
    step();
    chk("single_valid_lo", 32'(out_valid), 32'd0);
    chk("single_retired", retired_cnt, 32'd1);

    // Fill under back-pressure, then overflow
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++)
      retire(16'(i * 2), 16'(16'h1000 + i), i[0], 4'(i), 16'(16'hC000 + i), 1'b0, 1'b1);
    chk("fill_retired", retired_cnt, 32'd16);
    chk("fill_overflow", 32'(overflow), 32'd0);
    chk("fill_head_stamp", out_cycle, 32'd0);
    retire(16'hDEAD, 16'hBEEF, 1'b1, 4'hF, 16'hFFFF, 1'b0, 1'b0);
    chk("ovf_overflow", 32'(overflow), 32'd1);
    chk("ovf_dropped", 32'(dropped_cnt), 32'd1);
    chk("ovf_retired", retired_cnt, 32'd16);

    // Full with simultaneous push and pop
    out_ready = 1'b1;
    retire(16'h0100, 16'h2222, 1'b1, 4'd7, 16'h7777, 1'b0, 1'b1);
    out_ready = 1'b0;
    chk("fullpp_dropped", 32'(dropped_cnt), 32'd1);
    chk("fullpp_retired", retired_cnt, 32'd17);
    chk("fullpp_head_stamp", out_cycle, 32'd1);
    retire(16'h0200, 16'h3333, 1'b0, 4'd1, 16'h1111, 1'b0, 1'b0);
    chk("still_full_dropped", 32'(dropped_cnt), 32'd2);
    chk("still_full_retired", retired_cnt, 32'd17);
    out_ready = 1'b1;
    wait_drain(40);
    step();
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Payload gating with idle inputs
    wb_pc = 16'h5A5A; wb_instr = 16'hFFFF; wb_rf_we = 1'b1; wb_rd = 4'hC;
    wb_rf_wdata = 16'h1234; wb_hlt = 1'b1; wb_valid = 1'b0;
    step();
    chk("gate_valid", 32'(out_valid), 32'd0);
    chk("gate_payload", 32'(|{out_cycle, out_pc, out_instr, out_rf_we,
                               out_rd, out_wdata, out_hlt}), 32'd0);
    wb_hlt = 1'b0;

    // Reset mid-drain with 4 records pending
    out_ready = 1'b0;
    do_reset();
    retire(16'h0010, 16'h4001, 1'b1, 4'd1, 16'h0001, 1'b0, 1'b1);
    retire(16'h0012, 16'h4002, 1'b1, 4'd2, 16'h0002, 1'b0, 1'b1);
    retire(16'h0014, 16'h4003, 1'b1, 4'd3, 16'h0003, 1'b0, 1'b1);
    retire(16'h0016, 16'hF000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1);
    tb_run = 1'b0;
    step(); step();
    chk("drain_frozen", cycle_cnt, 32'd4);
    chk("drain_not_done", 32'(done), 32'd0);
    do_reset();
    chk_all_zero("midrst");
    out_ready = 1'b1;
    retire(16'h0020, 16'h5555, 1'b1, 4'd5, 16'hABCD, 1'b0, 1'b1);
    step();
    chk("midrst_running", cycle_cnt, 32'd2);
    chk("midrst_retired", retired_cnt, 32'd1);

    // HLT drain: 5 pending, HLT, 3 ignored retires, then drain to done
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++)
      retire(16'(16'h0040 + i), 16'(16'h6000 + i), 1'b1, 4'(i + 8), 16'(i * 3), 1'b0, 1'b1);
    retire(16'h0045, 16'hF000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1);
    tb_run = 1'b0;
    for (int i = 0; i < 3; i++)
      retire(16'(16'h0090 + i), 16'h7000, 1'b1, 4'd2, 16'h9999, 1'b0, 1'b0);
    chk("hlt_dropped", 32'(dropped_cnt), 32'd0);
    chk("hlt_overflow", 32'(overflow), 32'd0);
    chk("hlt_retired", retired_cnt, 32'd6);
    chk("hlt_frozen", cycle_cnt, 32'd6);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      chk("hlt_done_early", 32'(done), 32'd0);
      step();
    end
    chk("hlt_all_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    chk("hlt_done", 32'(done), 32'd1);
    chk("hlt_valid_lo", 32'(out_valid), 32'd0);
    step(); step(); step();
    chk("hlt_done_hold", 32'(done), 32'd1);
    chk("hlt_frozen_end", cycle_cnt, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
